ddr_loc_resp: RTL and testbench

DDR_LOC_RESP -- requirements
Module: ddr_loc_resp

---
 rtl/ddr_loc_resp.sv | 124 ++++++++++++
 tb/tb_ddr_loc_resp.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_loc_resp.sv
// DDR local-port responder: init/refresh sequencing FSM in front of a word
// memory, with a fixed-latency read return path that drains on its own.
//
// state   | meaning
// INIT    | post-reset wait, drinitok low
// IDLE    | arbitrating: refresh > write > read
// WRITE   | accepting write beats while loc_wreq is held
// READ    | accepting read beats while loc_rreq is held
// REFRESH | drrdy held low for REFRESH_CYC cycles
module ddr_loc_resp #(
    parameter int INIT_CYC    = 100,
    parameter int REFRESH_CYC = 8,
    parameter int MEM_AW      = 10,
    parameter int RD_LAT      = 2
) (
    input  logic        clkddr,
    input  logic        rstn,
    input  logic        loc_wreq,
    input  logic        loc_rreq,
    input  logic        loc_rshrq,
    input  logic [23:0] loc_addr,
    input  logic [31:0] loc_wdata,
    input  logic        stall,
    output logic        drinitok,
    output logic        drrdy,
    output logic [31:0] loc_rdata,
    output logic        loc_rdvalid,
    output logic        err_proto
);

    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, REFRESH} state_t;

    localparam int CNT_MAX = (INIT_CYC > REFRESH_CYC) ? INIT_CYC : REFRESH_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // Address stages ahead of the registered memory read.
    localparam int PD      = RD_LAT - 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              pend;
    logic              wr_beat;
    logic              rd_beat;
    logic              proto_bad;
    logic [MEM_AW-1:0] addr;
    logic [PD-1:0]     rd_v;
    logic [MEM_AW-1:0] rd_a [PD];
    logic [31:0]       mem  [2**MEM_AW];
    logic              unused_addr_hi;

    assign addr           = loc_addr[MEM_AW-1:0];
    assign unused_addr_hi = ^loc_addr[23:MEM_AW];

    assign drrdy   = ((state == WRITE) || (state == READ)) && !stall;
    assign wr_beat = drrdy && (state == WRITE) && loc_wreq;
    assign rd_beat = drrdy && (state == READ) && loc_rreq;

    assign proto_bad = (loc_wreq && loc_rreq)
                     || ((state == INIT) && (loc_wreq || loc_rreq))
                     || ((state == WRITE) && loc_rreq)
                     || ((state == READ) && loc_wreq);

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) begin
            state     <= INIT;
            cnt       <= CW'(INIT_CYC - 1);
            pend      <= 1'b0;
            drinitok  <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (proto_bad) err_proto <= 1'b1;
            // Refresh requests seen while busy coalesce into one pending flag.
            if (loc_rshrq && (state != INIT) && (state != IDLE)) pend <= 1'b1;
            case (state)
                INIT: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        drinitok <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                IDLE: begin
                    if (pend || loc_rshrq) begin
                        state <= REFRESH;
                        cnt   <= CW'(REFRESH_CYC - 1);
                        pend  <= 1'b0;
                    end else if (loc_wreq) begin
                        state <= WRITE;
                    end else if (loc_rreq) begin
                        state <= READ;
                    end
                end
                WRITE:   if (!loc_wreq) state <= IDLE;
                READ:    if (!loc_rreq) state <= IDLE;
                REFRESH: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= INIT;
            endcase
        end
    end

    // Memory and read addresses carry no reset; only the valid bits do.
    always_ff @(posedge clkddr) begin
        if (wr_beat) mem[addr] <= loc_wdata;
        rd_a[0] <= addr;
        for (int i = 1; i < PD; i++) rd_a[i] <= rd_a[i-1];
    end

    always_ff @(posedge clkddr or negedge rstn) begin
        if (!rstn) begin
            rd_v        <= '0;
            loc_rdvalid <= 1'b0;
            loc_rdata   <= '0;
        end else begin
            rd_v[0] <= rd_beat;
            for (int i = 1; i < PD; i++) rd_v[i] <= rd_v[i-1];
            loc_rdvalid <= rd_v[PD-1];
            if (rd_v[PD-1]) loc_rdata <= mem[rd_a[PD-1]];
        end
    end

endmodule

// File: tb/tb_ddr_loc_resp.sv
// Randomised bench for ddr_loc_resp: a word-memory model and a queue of
// expected read returns are checked against the DUT on every falling edge.
module tb_ddr_loc_resp;
    localparam int INIT_CYC    = 100;
    localparam int REFRESH_CYC = 8;
    localparam int MEM_AW      = 10;

    logic        clkddr = 1'b0;
    logic        rstn = 1'b0;
    logic        loc_wreq = 1'b0;
    logic        loc_rreq = 1'b0;
    logic        loc_rshrq = 1'b0;
    logic        stall = 1'b0;
    logic [23:0] loc_addr = '0;
    logic [31:0] loc_wdata = '0;
    logic        drinitok;
    logic        drrdy;
    logic [31:0] loc_rdata;
    logic        loc_rdvalid;
    logic        err_proto;

    ddr_loc_resp #(.INIT_CYC(INIT_CYC), .REFRESH_CYC(REFRESH_CYC), .MEM_AW(MEM_AW), .RD_LAT(2)) dut (
        .clkddr(clkddr), .rstn(rstn), .loc_wreq(loc_wreq), .loc_rreq(loc_rreq),
        .loc_rshrq(loc_rshrq), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .stall(stall),
        .drinitok(drinitok), .drrdy(drrdy), .loc_rdata(loc_rdata),
        .loc_rdvalid(loc_rdvalid), .err_proto(err_proto)
    );

    always #5 clkddr = ~clkddr;

    int cyc = 0;
    always @(posedge clkddr) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    int          nchk = 0;
    int          nerr = 0;
    int          wr_count = 0;
    int          n_rdv = 0;
    rd_exp_t     exp_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem_m [1024];
    logic [23:0] b_addr[$];
    logic [31:0] b_data[$];
    logic [9:0]  wlist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory indexed by low address bits, reads return 2 cycles after drrdy.
    always @(negedge clkddr) begin
        if (!rstn) begin
            exp_q.delete();
            chk1("rst_rdvalid", loc_rdvalid, 1'b0);
        end else begin
            if (loc_rdvalid) n_rdv++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk1("rdvalid", loc_rdvalid, 1'b1);
                chk("rdata", loc_rdata, exp_q[0].data);
                rd_log.push_back(loc_rdata);
                void'(exp_q.pop_front());
            end else begin
                chk1("rdvalid_idle", loc_rdvalid, 1'b0);
            end
            if (stall) chk1("stall_drrdy", drrdy, 1'b0);
            if (drrdy && loc_wreq) begin
                mem_m[loc_addr[MEM_AW-1:0]] = loc_wdata;
                wr_count++;
            end else if (drrdy && loc_rreq) begin
                exp_q.push_back('{cyc + 2, mem_m[loc_addr[MEM_AW-1:0]]});
            end
        end
    end

    task automatic tick();
        @(posedge clkddr);
        #2;
    endtask

    function automatic logic next_stall(input int smode, input int c);
        if (smode == 1) return c[0];
        if (smode == 2) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    task automatic burst(input bit is_wr, input int smode);
        int i = 0;
        int budget = 0;
        int n = b_addr.size();
        bit acc;
        tick();
        loc_addr  = b_addr[0];
        loc_wdata = is_wr ? b_data[0] : 32'h0;
        stall     = next_stall(smode, 0);
        if (is_wr) loc_wreq = 1'b1;
        else       loc_rreq = 1'b1;
        while (i < n && budget < 20 * n + 50) begin
            @(negedge clkddr);
            acc = drrdy && (is_wr ? loc_wreq : loc_rreq);
            tick();
            budget++;
            if (acc) begin
                i++;
                if (i < n) begin
                    loc_addr = b_addr[i];
                    if (is_wr) loc_wdata = b_data[i];
                end
            end
            stall = (i < n) ? next_stall(smode, budget) : 1'b0;
        end
        loc_wreq = 1'b0;
        loc_rreq = 1'b0;
        stall    = 1'b0;
        chk("burst_beats", i, n);
    endtask

    task automatic wait_init(input bit pulse);
        for (int k = 1; k <= INIT_CYC + 2; k++) begin
            tick();
            loc_wreq = pulse && (k == 10);
            chk1("init_drinitok", drinitok, k >= INIT_CYC);
            chk1("init_drrdy", drrdy, 1'b0);
        end
        chk1("init_err", err_proto, pulse);
    endtask

    task automatic do_reset(input bit pulse);
        tick();
        rstn = 1'b0;
        loc_wreq = 1'b0; loc_rreq = 1'b0; loc_rshrq = 1'b0; stall = 1'b0;
        repeat (3) tick();
        chk1("rst_drinitok", drinitok, 1'b0);
        chk1("rst_drrdy", drrdy, 1'b0);
        chk1("rst_err", err_proto, 1'b0);
        chk("rst_rdata", loc_rdata, 32'h0);
        rstn = 1'b1;
        wait_init(pulse);
    endtask

    task automatic wait_drrdy(input int t0, output int lat);
        lat = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clkddr);
            if (drrdy) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        int w0;
        int lat;
        int t0;
        int rv0;
        int nacc;
        bit acc;

        do_reset(1'b0);

        // 32-beat write then read of 0xA0..0xBF.
        b_addr.delete(); b_data.delete();
        for (int i = 0; i < 32; i++) begin
            b_addr.push_back(24'h0000A0 + 24'(i));
            b_data.push_back(32'h1000 + 32'(i));
            wlist.push_back(10'h0A0 + 10'(i));
        end
        w0 = wr_count;
        burst(1'b1, 0);
        chk("wr32_count", wr_count - w0, 32);
        rd_log.delete();
        burst(1'b0, 0);
        repeat (4) tick();
        chk("rd32_count", rd_log.size(), 32);
        chk("rd32_first", rd_log[0], 32'h1000);
        chk("rd32_last", rd_log[31], 32'h101F);

        // Stall toggling every cycle; random upper address bits alias to the same word.
        b_addr.delete(); b_data.delete();
        for (int i = 0; i < 32; i++) begin
            b_addr.push_back({14'($urandom), 10'h200 + 10'(i)});
            b_data.push_back($urandom);
            wlist.push_back(10'h200 + 10'(i));
        end
        w0 = wr_count;
        burst(1'b1, 1);
        chk("stall_wr_count", wr_count - w0, 32);
        for (int i = 0; i < 32; i++) b_addr[i] = {14'($urandom), 10'h200 + 10'(i)};
        rd_log.delete();
        burst(1'b0, 2);
        repeat (4) tick();
        chk("stall_rd_count", rd_log.size(), 32);
        chk("stall_rd_word5", rd_log[5], b_data[5]);

        // Two refresh pulses mid-read coalesce into a single refresh after the read.
        b_addr.delete();
        for (int i = 0; i < 32; i++) b_addr.push_back(24'h0000A0 + 24'(i));
        rd_log.delete();
        fork
            burst(1'b0, 0);
            begin
                repeat (8) tick();
                loc_rshrq = 1'b1; tick(); loc_rshrq = 1'b0;
                repeat (5) tick();
                loc_rshrq = 1'b1; tick(); loc_rshrq = 1'b0;
            end
        join
        tick();
        loc_addr = 24'h0003FF; loc_wdata = 32'hDEADBEEF; loc_wreq = 1'b1;
        t0 = cyc;
        wait_drrdy(t0, lat);
        tick();
        loc_wreq = 1'b0;
        repeat (3) tick();
        chk("refresh_rd_count", rd_log.size(), 32);
        chk("refresh_latency", lat, REFRESH_CYC + 2);
        chk1("refresh_err_clean", err_proto, 1'b0);

        // Random bursts with random stall; reads only touch written words.
        for (int r = 0; r < 12; r++) begin
            int len = $urandom_range(1, 8);
            bit is_wr = (r < 2) || ($urandom_range(0, 1) == 1);
            b_addr.delete(); b_data.delete();
            for (int i = 0; i < len; i++) begin
                if (is_wr) begin
                    logic [9:0] a = 10'h300 + 10'($urandom_range(0, 255));
                    b_addr.push_back({14'($urandom), a});
                    b_data.push_back($urandom);
                    wlist.push_back(a);
                end else begin
                    b_addr.push_back({14'($urandom), wlist[$urandom_range(0, wlist.size() - 1)]});
                end
            end
            burst(is_wr, 2);
            repeat ($urandom_range(3, 6)) tick();
        end
        chk("rand_queue_drained", exp_q.size(), 0);

        // Simultaneous write/read request in IDLE is served as a write and flagged.
        chk1("both_err_before", err_proto, 1'b0);
        tick();
        loc_addr = 24'h000150; loc_wdata = 32'hCAFE0001;
        loc_wreq = 1'b1; loc_rreq = 1'b1;
        w0 = wr_count;
        t0 = cyc;
        wait_drrdy(t0, lat);
        tick();
        loc_wreq = 1'b0; loc_rreq = 1'b0;
        repeat (3) tick();
        chk("both_latency", lat, 1);
        chk("both_wr_count", wr_count - w0, 1);
        chk1("both_err", err_proto, 1'b1);
        b_addr.delete(); b_addr.push_back(24'h000150);
        rd_log.delete();
        burst(1'b0, 0);
        repeat (4) tick();
        chk("both_readback", rd_log[0], 32'hCAFE0001);

        // Reset with two read beats in flight: nothing may come back afterwards.
        tick();
        loc_addr = 24'h0000A0; loc_rreq = 1'b1;
        nacc = 0;
        for (int j = 0; j < 40 && nacc < 2; j++) begin
            @(negedge clkddr);
            acc = drrdy && loc_rreq;
            tick();
            if (acc) begin
                nacc++;
                loc_addr = 24'h0000A0 + 24'(nacc);
            end
        end
        chk("inflight_beats", nacc, 2);
        rstn = 1'b0; loc_rreq = 1'b0;
        rv0 = n_rdv;
        repeat (3) tick();
        chk1("midrst_drinitok", drinitok, 1'b0);
        chk1("midrst_err", err_proto, 1'b0);
        rstn = 1'b1;
        wait_init(1'b1);
        chk("midrst_no_rdvalid", n_rdv - rv0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
